// File: rtl/seq_pkg.sv
// Shared types and constants for the fetch/execute sequencer.
package seq_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_MEM
    } seq_state_t;

    localparam logic [1:0] MODE_BZ  = 2'd0;
    localparam logic [1:0] MODE_BNZ = 2'd1;
    localparam logic [1:0] MODE_JMP = 2'd2;
    localparam logic [1:0] MODE_JMR = 2'd3;

    localparam logic [5:0] OP_LD  = 6'd16;
    localparam logic [5:0] OP_ST  = 6'd17;
    localparam logic [5:0] OP_JMR = 6'd18;
    localparam logic [5:0] OP_BZ  = 6'd19;
    localparam logic [5:0] OP_BNZ = 6'd20;
    localparam logic [5:0] OP_JMP = 6'd21;

endpackage

// File: rtl/branch_resolve.sv
// Next-PC selection: sequential, conditional/unconditional relative, or register target.
module branch_resolve
    import seq_pkg::*;
#(
    parameter int PC_W = 16
) (
    input  logic [PC_W-1:0] pc,
    input  logic            j,
    input  logic [1:0]      mode_sel,
    input  logic            zero,
    input  logic [15:0]     const_in,
    input  logic [PC_W-1:0] a_val,
    output logic [PC_W-1:0] next_pc
);

    logic [PC_W-1:0] seq_pc;
    logic [PC_W-1:0] off;

    assign seq_pc = pc + PC_W'(1);
    assign off    = PC_W'($signed(const_in));

    always_comb begin
        next_pc = seq_pc;
        if (j) begin
            unique case (mode_sel)
                MODE_BZ:  if (zero)  next_pc = seq_pc + off;
                MODE_BNZ: if (!zero) next_pc = seq_pc + off;
                MODE_JMP: next_pc = seq_pc + off;
                MODE_JMR: next_pc = a_val;
                default:  next_pc = seq_pc;
            endcase
        end
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle IDLE/FETCH/EXEC/MEM sequencer with PC and instruction register.
// SEQ_ACK_TIMEOUT_EN adds an ack watchdog with a sticky err flag.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            run,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_data,
    output logic [31:0]     op_code,
    input  logic            load_en,
    input  logic            data_sel,
    input  logic            write_en,
    input  logic            J,
    input  logic [1:0]      mode_sel,
    input  logic [15:0]     const_in,
    input  logic [PC_W-1:0] a_val,
    input  logic            zero,
    output logic            reg_we,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    output logic [PC_W-1:0] pc,
    output logic            err
);

    seq_state_t      state;
    logic [PC_W-1:0] next_pc;
    logic            mem_op;
    logic            tmo;

    branch_resolve #(.PC_W(PC_W)) u_br (
        .pc       (pc),
        .j        (J),
        .mode_sel (mode_sel),
        .zero     (zero),
        .const_in (const_in),
        .a_val    (a_val),
        .next_pc  (next_pc)
    );

    // Handshake strobes decode straight from the state flop so reset kills them at once.
    assign mem_op    = data_sel | write_en;
    assign imem_req  = (state == S_FETCH);
    assign imem_addr = pc;
    assign dmem_req  = (state == S_MEM);
    assign dmem_we   = dmem_req & write_en;
    assign reg_we    = ((state == S_EXEC) & ~mem_op & load_en)
                     | ((state == S_MEM) & dmem_ack & data_sel);

`ifdef SEQ_ACK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt;
    logic             waiting;

    assign waiting = ((state == S_FETCH) & ~imem_ack)
                   | ((state == S_MEM) & ~dmem_ack);
    assign tmo     = waiting & (cnt == CNT_W'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            err <= 1'b0;
        end else begin
            cnt <= (waiting && !tmo) ? cnt + CNT_W'(1) : '0;
            if (tmo) err <= 1'b1;
        end
    end
`else
    assign tmo = 1'b0;
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            pc      <= RESET_PC;
            op_code <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (run && !err) state <= S_FETCH;
                end
                S_FETCH: begin
                    if (imem_ack) begin
                        op_code <= imem_data;
                        state   <= S_EXEC;
                    end else if (tmo) begin
                        state <= S_IDLE;
                    end
                end
                S_EXEC: begin
                    if (mem_op) begin
                        state <= S_MEM;
                    end else begin
                        pc    <= next_pc;
                        state <= run ? S_FETCH : S_IDLE;
                    end
                end
                S_MEM: begin
                    if (dmem_ack) begin
                        pc    <= pc + PC_W'(1);
                        state <= run ? S_FETCH : S_IDLE;
                    end else if (tmo) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a small opcode decoder model.
module tb_instr_sequencer;
    import seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_data = '0;
    logic [31:0] op_code;
    logic        load_en, data_sel, write_en, J;
    logic [1:0]  mode_sel;
    logic [15:0] const_in;
    logic [15:0] a_val = '0;
    logic        zero = 1'b0;
    logic        reg_we, dmem_req, dmem_we;
    logic        dmem_ack = 1'b0;
    logic [15:0] pc;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_sequencer #(.PC_W(16), .RESET_PC(16'h0), .TIMEOUT(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .run       (run),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .op_code   (op_code),
        .load_en   (load_en),
        .data_sel  (data_sel),
        .write_en  (write_en),
        .J         (J),
        .mode_sel  (mode_sel),
        .const_in  (const_in),
        .a_val     (a_val),
        .zero      (zero),
        .reg_we    (reg_we),
        .dmem_req  (dmem_req),
        .dmem_we   (dmem_we),
        .dmem_ack  (dmem_ack),
        .pc        (pc),
        .err       (err)
    );

    // Decode unit model: opcode in [5:0], offset in [31:16].
    always_comb begin
        load_en  = 1'b0;
        data_sel = 1'b0;
        write_en = 1'b0;
        J        = 1'b0;
        mode_sel = MODE_BZ;
        const_in = op_code[31:16];
        case (op_code[5:0])
            6'd2:   load_en = 1'b1;
            OP_LD:  begin load_en = 1'b1; data_sel = 1'b1; end
            OP_ST:  write_en = 1'b1;
            OP_JMR: begin J = 1'b1; mode_sel = MODE_JMR; end
            OP_BZ:  begin J = 1'b1; mode_sel = MODE_BZ; end
            OP_BNZ: begin J = 1'b1; mode_sel = MODE_BNZ; end
            OP_JMP: begin J = 1'b1; mode_sel = MODE_JMP; end
            default: ;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ins(input logic [5:0] op, input logic [15:0] k);
        return {k, 10'd0, op};
    endfunction

    // Called at a negedge in FETCH; returns #1 after the next negedge, in EXEC.
    task automatic fetch(input logic [31:0] w);
        imem_data = w;
        imem_ack  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        imem_ack = 1'b0;
        #1;
    endtask

    task automatic next_neg();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic go_to(input logic [15:0] t);
        a_val = t;
        fetch(ins(OP_JMR, 16'h0));
        next_neg();
        a_val = '0;
    endtask

    task automatic run_branch(input logic [5:0] op, input logic [15:0] k,
                              input logic z, input logic [15:0] exp, input string tag);
        go_to(16'd10);
        zero = z;
        fetch(ins(op, k));
        next_neg();
        zero = 1'b0;
        chk(tag, 32'(pc), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        int n;

        // 1: reset, add, fetch resumes
        @(negedge clk);
        #1;
        chk("rst_imem_req", 32'(imem_req), 32'd0);
        chk("rst_pc", 32'(pc), 32'd0);
        chk("rst_op_code", op_code, 32'd0);
        chk("rst_reg_we", 32'(reg_we), 32'd0);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        run   = 1'b1;
        next_neg();
        chk("t1_req", 32'(imem_req), 32'd1);
        chk("t1_addr", 32'(imem_addr), 32'd0);
        fetch(ins(6'd2, 16'h0));
        chk("t1_op_code", op_code, 32'd2);
        chk("t1_reg_we", 32'(reg_we), 32'd1);
        chk("t1_req_exec", 32'(imem_req), 32'd0);
        next_neg();
        chk("t1_pc", 32'(pc), 32'd1);
        chk("t1_req_again", 32'(imem_req), 32'd1);
        chk("t1_addr_again", 32'(imem_addr), 32'd1);
        chk("t1_we_pulse", 32'(reg_we), 32'd0);

        // 2: load with 3-cycle memory, then store
        go_to(16'd4);
        chk("t2_pc4", 32'(pc), 32'd4);
        fetch(ins(OP_LD, 16'h0));
        chk("t2_ld_exec_we", 32'(reg_we), 32'd0);
        for (int i = 0; i < 3; i++) begin
            next_neg();
            if (i == 2) dmem_ack = 1'b1;
            #1;
            chk("t2_ld_dreq", 32'(dmem_req), 32'd1);
            chk("t2_ld_dwe", 32'(dmem_we), 32'd0);
            chk("t2_ld_reg_we", 32'(reg_we), (i == 2) ? 32'd1 : 32'd0);
        end
        next_neg();
        dmem_ack = 1'b0;
        #1;
        chk("t2_ld_pc", 32'(pc), 32'd5);
        chk("t2_ld_done", 32'(dmem_req), 32'd0);
        chk("t2_ld_we_off", 32'(reg_we), 32'd0);
        fetch(ins(OP_ST, 16'h0));
        chk("t2_st_exec_we", 32'(reg_we), 32'd0);
        for (int i = 0; i < 2; i++) begin
            next_neg();
            if (i == 1) dmem_ack = 1'b1;
            #1;
            chk("t2_st_dwe", 32'(dmem_we), 32'd1);
            chk("t2_st_reg_we", 32'(reg_we), 32'd0);
        end
        next_neg();
        dmem_ack = 1'b0;
        #1;
        chk("t2_st_pc", 32'(pc), 32'd6);

        // 3: branches and wrap
        run_branch(OP_BZ,  16'hFFFD, 1'b1, 16'd8,  "t3_bz_taken");
        run_branch(OP_BZ,  16'hFFFD, 1'b0, 16'd11, "t3_bz_not");
        run_branch(OP_BNZ, 16'hFFFD, 1'b0, 16'd8,  "t3_bnz_taken");
        run_branch(OP_BNZ, 16'hFFFD, 1'b1, 16'd11, "t3_bnz_not");
        go_to(16'h1234);
        chk("t3_jmr", 32'(pc), 32'h1234);
        go_to(16'hFFFF);
        fetch(ins(6'd0, 16'h0));
        chk("t3_nop_we", 32'(reg_we), 32'd0);
        next_neg();
        chk("t3_wrap", 32'(pc), 32'd0);
        fetch(ins(OP_JMP, 16'd5));
        next_neg();
        chk("t3_jmp", 32'(pc), 32'd6);

        // 4: run dropped during MEM
        fetch(ins(OP_ST, 16'h0));
        next_neg();
        run      = 1'b0;
        dmem_ack = 1'b1;
        next_neg();
        dmem_ack = 1'b0;
        #1;
        chk("t4_pc", 32'(pc), 32'd7);
        n = 0;
        for (int i = 0; i < 4; i++) begin
            if (imem_req) n++;
            next_neg();
        end
        chk("t4_no_req", 32'(n), 32'd0);
        run = 1'b1;
        next_neg();
        chk("t4_resume_req", 32'(imem_req), 32'd1);
        chk("t4_resume_addr", 32'(imem_addr), 32'd7);

        // 5: async reset mid-FETCH and mid-MEM
        rst_n = 1'b0;
        #1;
        chk("t5_f_req", 32'(imem_req), 32'd0);
        chk("t5_f_pc", 32'(pc), 32'd0);
        chk("t5_f_op", op_code, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        next_neg();
        go_to(16'd3);
        fetch(ins(OP_LD, 16'h0));
        next_neg();
        chk("t5_m_pre", 32'(dmem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_m_req", 32'(dmem_req), 32'd0);
        chk("t5_m_we", 32'(reg_we), 32'd0);
        chk("t5_m_pc", 32'(pc), 32'd0);
        chk("t5_m_op", op_code, 32'd0);

        // 6: imem_ack never arrives
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
`ifdef SEQ_ACK_TIMEOUT_EN
        for (int i = 0; i < 20; i++) begin
            next_neg();
            if (imem_req) n++;
        end
        chk("t6_req_cycles", 32'(n), 32'd8);
        chk("t6_err", 32'(err), 32'd1);
        chk("t6_req_off", 32'(imem_req), 32'd0);
        chk("t6_pc", 32'(pc), 32'd0);
`else
        for (int i = 0; i < 100; i++) begin
            next_neg();
            if (imem_req) n++;
        end
        chk("t6_req_cycles", 32'(n), 32'd100);
        chk("t6_err", 32'(err), 32'd0);
        chk("t6_req_on", 32'(imem_req), 32'd1);
        chk("t6_pc", 32'(pc), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
